// File: rtl/lau_pkg.sv
// Shared library package: parity sense encoding and small constant helpers.
package lau_pkg;

  // Parity sense carried by a link: even means the XOR of data and parity is 0.
  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_e;

  // Floor of log2 for elaboration-time constants; returns 0 for n <= 1.
  function automatic int unsigned log2floor(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned v = n; v > 1; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/RedXor.sv
// Reduction XOR of a word; used both to generate and to check parity.
module RedXor #(
  parameter int unsigned width = 8
) (
  input  logic [width-1:0] data_i,
  output logic             par_o
);

  assign par_o = ^data_i;

endmodule

// File: rtl/parity_check_stream.sv
// Receive-side parity checker on a valid/ready stream.
// Each accepted word travels through a chain of register slices together with
// its parity error flag; delivered errors drive a saturating counter and a
// sticky flag. Optional macro PARITY_CHECK_STREAM_FIRST_ERR_EN adds a capture
// of the first erroneous delivered word.
module parity_check_stream
  import lau_pkg::*;
#(
  parameter int unsigned width  = 8,
  parameter int unsigned odd    = 0,
  parameter int unsigned stages = 1,
  parameter int unsigned cntw   = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [width-1:0] in_data_i,
  input  logic             in_par_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [width-1:0] out_data_o,
  output logic             out_err_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  input  logic             clr_i,
  output logic [cntw-1:0]  err_cnt_o,
  output logic             err_sticky_o
`ifdef PARITY_CHECK_STREAM_FIRST_ERR_EN
  ,
  output logic [width-1:0] first_err_data_o
`endif
);

  localparam parity_e         sense   = (odd != 0) ? ODD : EVEN;
  localparam logic [cntw-1:0] cnt_one = cntw'(1);
  localparam logic [cntw-1:0] cnt_max = '1;

  if (stages < 1 || stages > 2) begin : g_bad_stages
    $error("parity_check_stream: stages must be 1 or 2");
  end

  logic red_par;
  logic in_err;
  logic err_hs;

  RedXor #(
    .width(width + 1)
  ) u_red_xor (
    .data_i({in_data_i, in_par_i}),
    .par_o (red_par)
  );

  assign in_err = red_par ^ (sense == ODD);

  for (genvar i = 0; i < stages; i++) begin : g_slice
    logic             up_valid;
    logic [width-1:0] up_data;
    logic             up_err;
    logic             down_ready;
    logic             ready;
    logic             valid_q;
    logic [width-1:0] data_q;
    logic             err_q;

    if (i == 0) begin : g_head
      assign up_valid = in_valid_i;
      assign up_data  = in_data_i;
      assign up_err   = in_err;
    end else begin : g_link
      assign up_valid = g_slice[i-1].valid_q;
      assign up_data  = g_slice[i-1].data_q;
      assign up_err   = g_slice[i-1].err_q;
    end

    if (i == stages - 1) begin : g_tail
      assign down_ready = out_ready_i;
    end else begin : g_mid
      assign down_ready = g_slice[i+1].ready;
    end

    assign ready = !valid_q || down_ready;

    // Slice takes a new word (or drains to empty) whenever it is ready, holds otherwise
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        err_q   <= 1'b0;
      end else if (ready) begin
        valid_q <= up_valid;
        if (up_valid) begin
          data_q <= up_data;
          err_q  <= up_err;
        end
      end
    end
  end

  assign in_ready_o  = g_slice[0].ready;
  assign out_valid_o = g_slice[stages-1].valid_q;
  assign out_data_o  = g_slice[stages-1].data_q;
  assign out_err_o   = g_slice[stages-1].err_q;

  assign err_hs = out_valid_o & out_ready_i & out_err_o;

  // Error statistics counted on delivery; a clear in the same cycle still keeps that error
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_o    <= '0;
      err_sticky_o <= 1'b0;
    end else if (clr_i) begin
      err_cnt_o    <= err_hs ? cnt_one : '0;
      err_sticky_o <= err_hs;
    end else if (err_hs) begin
      if (err_cnt_o != cnt_max) begin
        err_cnt_o <= err_cnt_o + cnt_one;
      end
      err_sticky_o <= 1'b1;
    end
  end

`ifdef PARITY_CHECK_STREAM_FIRST_ERR_EN
  logic [width-1:0] first_err_q;

  // Remember the first erroneous delivered word until the next clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      first_err_q <= '0;
    end else if (clr_i) begin
      first_err_q <= err_hs ? out_data_o : '0;
    end else if (err_hs && !err_sticky_o) begin
      first_err_q <= out_data_o;
    end
  end

  assign first_err_data_o = first_err_q;
`endif

endmodule
